// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller driving a dual-port RAM: pointers, occupancy, flags and error pulses.
// Optional almost_full/almost_empty outputs are enabled by defining FIFO_ALMOST_FLAGS_EN.
module sync_fifo_ctrl #(
    parameter int ADDR_SIZE = 3,
    parameter int AF_LEVEL  = 6,
    parameter int AE_LEVEL  = 2
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 push,
    input  logic                 pop,
    output logic                 ram_write,
    output logic [ADDR_SIZE-1:0] ram_wr_addrs,
    output logic                 ram_read,
    output logic [ADDR_SIZE-1:0] ram_rd_addrs,
    output logic                 rd_valid,
    output logic                 full,
    output logic                 empty,
    output logic [ADDR_SIZE:0]   count,
`ifdef FIFO_ALMOST_FLAGS_EN
    output logic                 almost_full,
    output logic                 almost_empty,
`endif
    output logic                 overflow,
    output logic                 underflow
);
    localparam int PW = ADDR_SIZE + 1;

    // Thresholds beyond the depth could never assert; catch that at elaboration.
    if (AF_LEVEL > (2 ** ADDR_SIZE) || AE_LEVEL > (2 ** ADDR_SIZE)) begin : g_level_check
        $error("sync_fifo_ctrl: AF_LEVEL/AE_LEVEL exceed FIFO depth");
    end

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr_nxt;
    logic [PW-1:0] rd_ptr_nxt;
    logic [PW-1:0] count_nxt;
    logic          push_ok;
    logic          pop_ok;
    logic          full_nxt;
    logic          empty_nxt;

    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    assign ram_write    = push_ok;
    assign ram_read     = pop_ok;
    assign ram_wr_addrs = wr_ptr[ADDR_SIZE-1:0];
    assign ram_rd_addrs = rd_ptr[ADDR_SIZE-1:0];

    always_comb begin
        wr_ptr_nxt = wr_ptr + {{ADDR_SIZE{1'b0}}, push_ok};
        rd_ptr_nxt = rd_ptr + {{ADDR_SIZE{1'b0}}, pop_ok};
        count_nxt  = count;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
        // Wrap bit differs with equal low bits only when writer is a full lap ahead.
        full_nxt  = (wr_ptr_nxt[ADDR_SIZE] != rd_ptr_nxt[ADDR_SIZE]) &&
                    (wr_ptr_nxt[ADDR_SIZE-1:0] == rd_ptr_nxt[ADDR_SIZE-1:0]);
        empty_nxt = (wr_ptr_nxt == rd_ptr_nxt);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            count     <= count_nxt;
            full      <= full_nxt;
            empty     <= empty_nxt;
            rd_valid  <= pop_ok;
            overflow  <= push & full;
            underflow <= pop & empty;
        end
    end

`ifdef FIFO_ALMOST_FLAGS_EN
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (count_nxt >= PW'(AF_LEVEL));
            almost_empty <= (count_nxt <= PW'(AE_LEVEL));
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl with an 8x16 RAM model attached to its strobes.
// Define FIFO_ALMOST_FLAGS_EN to also exercise almost_full/almost_empty.
module tb_sync_fifo_ctrl;
    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic        ram_write;
    logic [2:0]  ram_wr_addrs;
    logic        ram_read;
    logic [2:0]  ram_rd_addrs;
    logic        rd_valid;
    logic        full;
    logic        empty;
    logic [3:0]  count;
    logic        overflow;
    logic        underflow;
`ifdef FIFO_ALMOST_FLAGS_EN
    logic        almost_full;
    logic        almost_empty;
`endif

    int tests = 0;
    int fails = 0;

    logic [15:0] mem [8];
    logic [15:0] data_out;
    logic [15:0] wdata = 16'h0;

    always #5 clk = ~clk;

    // RAM with registered read port: same-address read/write returns the old word.
    always @(posedge clk) begin
        if (ram_write) mem[ram_wr_addrs] <= wdata;
        if (ram_read)  data_out <= mem[ram_rd_addrs];
    end

    sync_fifo_ctrl #(.ADDR_SIZE(3), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
        .clk(clk), .clr(clr), .push(push), .pop(pop),
        .ram_write(ram_write), .ram_wr_addrs(ram_wr_addrs),
        .ram_read(ram_read), .ram_rd_addrs(ram_rd_addrs),
        .rd_valid(rd_valid), .full(full), .empty(empty), .count(count),
`ifdef FIFO_ALMOST_FLAGS_EN
        .almost_full(almost_full), .almost_empty(almost_empty),
`endif
        .overflow(overflow), .underflow(underflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic p, input logic q);
        push = p;
        pop  = q;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);
        @(posedge clk);
        #1 clr = 1'b0;

        // Fill with 8 pushes; write strobe and address checked before each edge
        for (int i = 0; i < 8; i++) begin
            wdata = 16'hA000 + 16'(i);
            push = 1'b1;
            #1;
            chk("fill_wr", ram_write, 1);
            chk("fill_wr_addr", ram_wr_addrs, i);
            tick(1'b1, 1'b0);
            chk("fill_count", count, i + 1);
            chk("fill_empty", empty, 0);
        end
        chk("full_flag", full, 1);
        push = 1'b1;
        #1 chk("full_no_wr", ram_write, 0);
        tick(1'b1, 1'b0);
        chk("ovf_pulse", overflow, 1);
        chk("ovf_count", count, 8);
        tick(1'b0, 1'b0);
        chk("ovf_drop", overflow, 0);

        // Drain 8 pops; data must come out A000..A007 one cycle after each pop
        for (int i = 0; i < 8; i++) begin
            pop = 1'b1;
            #1;
            chk("drain_rd", ram_read, 1);
            chk("drain_rd_addr", ram_rd_addrs, i);
            tick(1'b0, 1'b1);
            chk("drain_valid", rd_valid, 1);
            chk("drain_data", data_out, 16'hA000 + 16'(i));
            chk("drain_count", count, 7 - i);
        end
        chk("drain_empty", empty, 1);
        chk("drain_full", full, 0);
        tick(1'b0, 1'b0);
        chk("drain_valid_drop", rd_valid, 0);

        // Wrap: 20 push/pop pairs, addresses continue from 0 and roll over 7->0
        for (int k = 0; k < 20; k++) begin
            wdata = 16'hB000 + 16'(k);
            push = 1'b1;
            #1 chk("wrap_wr_addr", ram_wr_addrs, k % 8);
            tick(1'b1, 1'b0);
            chk("wrap_count1", count, 1);
            chk("wrap_ovf", overflow, 0);
            tick(1'b0, 1'b1);
            chk("wrap_data", data_out, 16'hB000 + 16'(k));
            chk("wrap_count0", count, 0);
            chk("wrap_unf", underflow, 0);
        end

        // Simultaneous push & pop at count 3 (pointers now at address 4)
        for (int i = 0; i < 3; i++) begin
            wdata = 16'hC000 + 16'(i);
            tick(1'b1, 1'b0);
        end
        chk("sim_pre_count", count, 3);
        wdata = 16'hC003;
        tick(1'b1, 1'b1);
        chk("sim_count", count, 3);
        chk("sim_valid", rd_valid, 1);
        chk("sim_data", data_out, 16'hC000);
        for (int i = 4; i < 9; i++) begin
            wdata = 16'hC000 + 16'(i);
            tick(1'b1, 1'b0);
        end
        chk("sim_full", full, 1);
        chk("sim_full_count", count, 8);
        wdata = 16'hCFFF;
        push = 1'b1;
        pop = 1'b1;
        #1;
        chk("fullpp_no_wr", ram_write, 0);
        chk("fullpp_rd", ram_read, 1);
        tick(1'b1, 1'b1);
        chk("fullpp_count", count, 7);
        chk("fullpp_ovf", overflow, 1);
        chk("fullpp_data", data_out, 16'hC001);
        chk("fullpp_full", full, 0);

        // Async clear mid-stream at count 5
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        chk("clr_pre_count", count, 5);
        chk("clr_pre_valid", rd_valid, 1);
        #2 clr = 1'b1;
        #1;
        chk("clr_count", count, 0);
        chk("clr_empty", empty, 1);
        chk("clr_full", full, 0);
        chk("clr_valid", rd_valid, 0);
        clr = 1'b0;
        pop = 1'b1;
        #1 chk("clr_no_rd", ram_read, 0);
        tick(1'b0, 1'b1);
        chk("unf_pulse", underflow, 1);
        chk("unf_valid", rd_valid, 0);
        chk("unf_count", count, 0);
        tick(1'b0, 1'b0);
        chk("unf_drop", underflow, 0);

`ifdef FIFO_ALMOST_FLAGS_EN
        chk("ae_idle", almost_empty, 1);
        chk("af_idle", almost_full, 0);
        for (int i = 1; i <= 8; i++) begin
            tick(1'b1, 1'b0);
            chk("af_fill", almost_full, (i >= 6) ? 1 : 0);
            chk("ae_fill", almost_empty, (i <= 2) ? 1 : 0);
        end
        for (int i = 7; i >= 0; i--) begin
            tick(1'b0, 1'b1);
            chk("af_drain", almost_full, (i >= 6) ? 1 : 0);
            chk("ae_drain", almost_empty, (i <= 2) ? 1 : 0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its end, expected completion");
        $fatal(1, "timeout");
    end
endmodule
